key_conditioner: RTL

//   Input conditioning stage directly upstream of the SLC-3 top-level CPU: synchronises and debounces
//   raw board pushbuttons (Run, Continue, ...) and synchronises the 16-bit switch bank.

---
 rtl/key_conditioner.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: input conditioning in front of the SLC-3 CPU.
// Each pushbutton passes through a 2-flop synchroniser and a four-state debounce FSM.
// The FSM produces a clean level plus one-cycle press and release pulses.
// The switch bank is only synchronised; it is not debounced.
// Keys are fully independent of each other.

module key_conditioner #(
   parameter int NUM_KEYS        = 3,
   parameter int SW_W            = 16,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [NUM_KEYS-1:0] KEY_N,
   input  logic [SW_W-1:0]     SW_raw,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [SW_W-1:0]     SW_sync
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_UP        = 2'd0,
      ST_WAIT_DOWN = 2'd1,
      ST_DOWN      = 2'd2,
      ST_WAIT_UP   = 2'd3
   } key_state_t;

   // Synchronisers hold the pressed sense (1 = pressed); reset value 0 means "released".
   logic [NUM_KEYS-1:0] key_meta_r;
   logic [NUM_KEYS-1:0] key_sync_r;
   logic [SW_W-1:0]     sw_meta_r;
   logic [SW_W-1:0]     sw_sync_r;

   // Two-flop synchronisers for the inverted keys and the raw switches.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         key_meta_r <= {NUM_KEYS{1'b0}};
         key_sync_r <= {NUM_KEYS{1'b0}};
         sw_meta_r  <= {SW_W{1'b0}};
         sw_sync_r  <= {SW_W{1'b0}};
      end else begin
         key_meta_r <= ~KEY_N;
         key_sync_r <= key_meta_r;
         sw_meta_r  <= SW_raw;
         sw_sync_r  <= sw_meta_r;
      end
   end

   assign SW_sync = sw_sync_r;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_state_t       state_r;
      key_state_t       state_s;
      logic [CNT_W-1:0] cnt_r;
      logic [CNT_W-1:0] cnt_s;
      logic             level_r;
      logic             level_s;
      logic             press_r;
      logic             press_s;
      logic             release_r;
      logic             release_s;
      logic             pressed_s;

      assign pressed_s = key_sync_r[k];

      // Debounce state, counter and registered outputs for this key.
      always_ff @(posedge Clk or posedge Reset) begin
         if (Reset) begin
            state_r   <= ST_UP;
            cnt_r     <= CNT_ZERO;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
         end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            level_r   <= level_s;
            press_r   <= press_s;
            release_r <= release_s;
         end
      end

      // Next-state logic: the count tracks consecutive samples that disagree with the stable level.
      always_comb begin
         state_s   = state_r;
         cnt_s     = cnt_r;
         level_s   = level_r;
         press_s   = 1'b0;
         release_s = 1'b0;
         case (state_r)
            ST_UP: begin
               if (pressed_s) begin
                  state_s = ST_WAIT_DOWN;
                  cnt_s   = CNT_ONE;
               end else begin
                  state_s = ST_UP;
               end
            end
            ST_WAIT_DOWN: begin
               if (!pressed_s) begin
                  // Bounce back to released: discard the partial count silently.
                  state_s = ST_UP;
                  cnt_s   = CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_s = ST_DOWN;
                  cnt_s   = CNT_ZERO;
                  level_s = 1'b1;
                  press_s = 1'b1;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            ST_DOWN: begin
               if (!pressed_s) begin
                  state_s = ST_WAIT_UP;
                  cnt_s   = CNT_ONE;
               end else begin
                  state_s = ST_DOWN;
               end
            end
            ST_WAIT_UP: begin
               if (pressed_s) begin
                  // Release glitch: level stays pressed.
                  state_s = ST_DOWN;
                  cnt_s   = CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_s   = ST_UP;
                  cnt_s     = CNT_ZERO;
                  level_s   = 1'b0;
                  release_s = 1'b1;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_s = ST_UP;
               cnt_s   = CNT_ZERO;
               level_s = 1'b0;
            end
         endcase
      end

      assign key_level[k]   = level_r;
      assign key_press[k]   = press_r;
      assign key_release[k] = release_r;
   end

endmodule
